// File: rtl/tft_bus_target_pkg.sv
// Shared definitions for the 8080-style TFT bus responder: ILI9341 opcodes
// and the decode FSM state type.
package tft_bus_target_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_MADCTL,
        ST_RAMWR,
        ST_SKIP
    } state_t;

endpackage

// File: rtl/tft_bus_target_pin_sync.sv
// Pin synchronizer for the TFT bus: all pins share one delay chain so rs/data
// stay aligned with the synced WR, plus a rising-edge detect on WR.
module tft_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tft_wr_n,
    input  logic        tft_rs,
    input  logic        tft_reset_n,
    input  logic [15:0] tft_data,
    output logic        commit,
    output logic        rs_s,
    output logic [15:0] data_s,
    output logic        reset_n_s
);

    // Bundle layout: {wr_n, rs, reset_n, data[15:0]}; idle pins are wr_n=1, reset_n=1.
    localparam logic [18:0] PINS_IDLE = {1'b1, 1'b0, 1'b1, 16'h0000};

    logic [18:0] sync_q [SYNC_STAGES];
    logic        wr_s_d;
    logic        wr_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= PINS_IDLE;
            end
            wr_s_d <= 1'b1;
        end else begin
            sync_q[0] <= {tft_wr_n, tft_rs, tft_reset_n, tft_data};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            wr_s_d <= wr_s;
        end
    end

    assign wr_s      = sync_q[SYNC_STAGES-1][18];
    assign rs_s      = sync_q[SYNC_STAGES-1][17];
    assign reset_n_s = sync_q[SYNC_STAGES-1][16];
    assign data_s    = sync_q[SYNC_STAGES-1][15:0];
    assign commit    = wr_s & ~wr_s_d;

endmodule

// File: rtl/tft_bus_target.sv
// Responder end of the 16-bit 8080 TFT bus: decodes ILI9341 commands, tracks
// the CASET/PASET window and turns RAMWR data into addressed pixel writes.
module tft_bus_target
    import tft_bus_target_pkg::*;
#(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tft_wr_n,
    input  logic        tft_rs,
    input  logic        tft_rd_n,
    input  logic        tft_reset_n,
    input  logic [15:0] tft_data,
    output logic        pix_we,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        cmd_strobe,
    output logic [7:0]  cmd_code,
    output logic [7:0]  madctl,
    output logic        sleep_out,
    output logic        display_on
);

    localparam logic [8:0] EC_INIT  = 9'(WIDTH - 1);
    localparam logic [8:0] EP_INIT  = 9'(HEIGHT - 1);
    localparam logic [9:0] WIDTH_L  = 10'(WIDTH);
    localparam logic [9:0] HEIGHT_L = 10'(HEIGHT);

    logic        commit;
    logic        rs_s;
    logic        reset_n_s;
    logic [15:0] data_s;

    tft_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .tft_wr_n    (tft_wr_n),
        .tft_rs      (tft_rs),
        .tft_reset_n (tft_reset_n),
        .tft_data    (tft_data),
        .commit      (commit),
        .rs_s        (rs_s),
        .data_s      (data_s),
        .reset_n_s   (reset_n_s)
    );

    // Read-back is not supported; the strobe is accepted and ignored.
    logic unused_rd_n;
    assign unused_rd_n = tft_rd_n;

    state_t     state;
    logic [1:0] param_idx;
    logic [8:0] sc, ec, sp, ep;
    logic [8:0] x, y;
    logic [8:0] sh_start;
    logic       sh_end_hi;

    logic [7:0] byte_s;
    logic [8:0] end_val;
    logic       soft_rst;
    logic       visible;

    assign byte_s   = data_s[7:0];
    assign end_val  = {sh_end_hi, byte_s};
    assign soft_rst = !reset_n_s || (commit && !rs_s && byte_s == CMD_SWRESET);
    assign visible  = ({1'b0, x} < WIDTH_L) && ({1'b0, y} < HEIGHT_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            param_idx  <= '0;
            sc         <= '0;
            ec         <= EC_INIT;
            sp         <= '0;
            ep         <= EP_INIT;
            x          <= '0;
            y          <= '0;
            sh_start   <= '0;
            sh_end_hi  <= 1'b0;
            pix_we     <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_data   <= '0;
            cmd_strobe <= 1'b0;
            cmd_code   <= '0;
            madctl     <= '0;
            sleep_out  <= 1'b0;
            display_on <= 1'b0;
        end else if (soft_rst) begin
            state      <= ST_IDLE;
            param_idx  <= '0;
            sc         <= '0;
            ec         <= EC_INIT;
            sp         <= '0;
            ep         <= EP_INIT;
            x          <= '0;
            y          <= '0;
            sh_start   <= '0;
            sh_end_hi  <= 1'b0;
            pix_we     <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_data   <= '0;
            cmd_strobe <= 1'b0;
            cmd_code   <= '0;
            madctl     <= '0;
            sleep_out  <= 1'b0;
            display_on <= 1'b0;
        end else begin
            pix_we     <= 1'b0;
            cmd_strobe <= 1'b0;
            if (commit) begin
                if (!rs_s) begin
                    cmd_strobe <= 1'b1;
                    cmd_code   <= byte_s;
                    param_idx  <= '0;
                    case (byte_s)
                        CMD_CASET:   state <= ST_CASET;
                        CMD_PASET:   state <= ST_PASET;
                        CMD_MADCTL:  state <= ST_MADCTL;
                        CMD_RAMWR: begin
                            state <= ST_RAMWR;
                            x     <= sc;
                            y     <= sp;
                        end
                        CMD_SLPIN:   begin sleep_out  <= 1'b0; state <= ST_IDLE; end
                        CMD_SLPOUT:  begin sleep_out  <= 1'b1; state <= ST_IDLE; end
                        CMD_DISPOFF: begin display_on <= 1'b0; state <= ST_IDLE; end
                        CMD_DISPON:  begin display_on <= 1'b1; state <= ST_IDLE; end
                        default:     state <= ST_SKIP;
                    endcase
                end else begin
                    case (state)
                        ST_CASET, ST_PASET: begin
                            param_idx <= param_idx + 2'd1;
                            // Only the final byte touches the live window, so an
                            // interrupted CASET/PASET leaves it intact.
                            case (param_idx)
                                2'd0: sh_start[8]   <= byte_s[0];
                                2'd1: sh_start[7:0] <= byte_s;
                                2'd2: sh_end_hi     <= byte_s[0];
                                default: begin
                                    if (state == ST_CASET) begin
                                        sc <= sh_start;
                                        ec <= end_val;
                                    end else begin
                                        sp <= sh_start;
                                        ep <= end_val;
                                    end
                                    state <= ST_SKIP;
                                end
                            endcase
                        end
                        ST_MADCTL: begin
                            madctl <= byte_s;
                            state  <= ST_SKIP;
                        end
                        ST_RAMWR: begin
                            if (visible) begin
                                pix_we   <= 1'b1;
                                pix_x    <= x;
                                pix_y    <= y;
                                pix_data <= data_s;
                            end
                            if (x == ec) begin
                                x <= sc;
                                y <= (y == ep) ? sp : y + 9'd1;
                            end else begin
                                x <= x + 9'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tft_bus_target.sv
// Randomized scoreboard bench for tft_bus_target against a queue-based model
// of the bus protocol, with pixel/command latency checked per transfer.
`timescale 1ns/1ps
module tb_tft_bus_target;

    localparam int W  = 40;
    localparam int H  = 12;
    localparam int SS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_n = 1'b1;
    logic        rs = 1'b0;
    logic        rd_n = 1'b1;
    logic        reset_n = 1'b1;
    logic [15:0] data = '0;

    logic        pix_we;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_data;
    logic        cmd_strobe;
    logic [7:0]  cmd_code;
    logic [7:0]  madctl;
    logic        sleep_out;
    logic        display_on;

    tft_bus_target #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tft_wr_n    (wr_n),
        .tft_rs      (rs),
        .tft_rd_n    (rd_n),
        .tft_reset_n (reset_n),
        .tft_data    (data),
        .pix_we      (pix_we),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .cmd_strobe  (cmd_strobe),
        .cmd_code    (cmd_code),
        .madctl      (madctl),
        .sleep_out   (sleep_out),
        .display_on  (display_on)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;
    int pix_seen = 0;

    typedef struct { int x; int y; int d; int at; } pix_t;
    typedef struct { int code; int at; } cmd_t;
    pix_t pq[$];
    cmd_t cq[$];

    // Reference model: bus meaning expressed with plain integers and a parameter list.
    localparam int M_IDLE = 0, M_CASET = 1, M_PASET = 2, M_MAD = 3, M_RAM = 4;
    int m_mode, sc, ec, sp, ep, px, py, m_mad, m_slp, m_dsp;
    int pbuf[$];

    function automatic void model_reset();
        sc = 0; ec = W - 1; sp = 0; ep = H - 1;
        px = 0; py = 0;
        m_mad = 0; m_slp = 0; m_dsp = 0;
        m_mode = M_IDLE;
        pbuf.delete();
    endfunction

    function automatic void model_cmd(int c);
        cmd_t e;
        if (c == 'h01) begin
            model_reset();
            return;
        end
        e.code = c; e.at = cyc + SS + 1;
        cq.push_back(e);
        pbuf.delete();
        m_mode = M_IDLE;
        case (c)
            'h2A: m_mode = M_CASET;
            'h2B: m_mode = M_PASET;
            'h36: m_mode = M_MAD;
            'h2C: begin m_mode = M_RAM; px = sc; py = sp; end
            'h10: m_slp = 0;
            'h11: m_slp = 1;
            'h28: m_dsp = 0;
            'h29: m_dsp = 1;
            default: ;
        endcase
    endfunction

    function automatic void model_data(int d);
        pix_t e;
        int s, f;
        if (m_mode == M_CASET || m_mode == M_PASET) begin
            pbuf.push_back(d % 256);
            if (pbuf.size() == 4) begin
                s = (pbuf[0] * 256 + pbuf[1]) % 512;
                f = (pbuf[2] * 256 + pbuf[3]) % 512;
                if (m_mode == M_CASET) begin sc = s; ec = f; end
                else begin sp = s; ep = f; end
                m_mode = M_IDLE;
            end
        end else if (m_mode == M_MAD) begin
            m_mad = d % 256;
            m_mode = M_IDLE;
        end else if (m_mode == M_RAM) begin
            if (px < W && py < H) begin
                e.x = px; e.y = py; e.d = d; e.at = cyc + SS + 1;
                pq.push_back(e);
            end
            if (px == ec) begin
                px = sc;
                py = (py == ep) ? sp : (py + 1) % 512;
            end else begin
                px = (px + 1) % 512;
            end
        end
    endfunction

    // Monitor: every strobe pops the matching expectation, including its cycle.
    always @(negedge clk) begin
        pix_t ep_;
        cmd_t ec_;
        if (pix_we) begin
            pix_seen++;
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("FAIL pix_unexpected: got (%0d,%0d)=%h at cyc %0d, required no write",
                         pix_x, pix_y, pix_data, cyc);
            end else begin
                ep_ = pq.pop_front();
                if (int'(pix_x) != ep_.x || int'(pix_y) != ep_.y ||
                    int'(pix_data) != ep_.d || cyc != ep_.at) begin
                    errors++;
                    $display("FAIL pix: got (%0d,%0d)=%h at cyc %0d, required (%0d,%0d)=%h at cyc %0d",
                             pix_x, pix_y, pix_data, cyc, ep_.x, ep_.y, ep_.d[15:0], ep_.at);
                end
            end
        end
        if (cmd_strobe) begin
            checks++;
            if (cq.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected: got %h at cyc %0d, required no strobe", cmd_code, cyc);
            end else begin
                ec_ = cq.pop_front();
                if (int'(cmd_code) != ec_.code || cyc != ec_.at) begin
                    errors++;
                    $display("FAIL cmd: got %h at cyc %0d, required %h at cyc %0d",
                             cmd_code, cyc, ec_.code[7:0], ec_.at);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input bit r, input logic [15:0] d);
        @(negedge clk);
        rs = r; data = d; wr_n = 1'b0;
        repeat (SS + 1) @(negedge clk);
        wr_n = 1'b1;
        if (r) model_data(int'(d));
        else   model_cmd(int'(d[7:0]));
        repeat (SS + 1) @(negedge clk);
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_madctl"},     int'(madctl),     m_mad);
        chk({tag, "_sleep_out"},  int'(sleep_out),  m_slp);
        chk({tag, "_display_on"}, int'(display_on), m_dsp);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix_we"},  int'(pix_we),     0);
        chk({tag, "_pix_xy"},  int'({pix_x, pix_y}), 0);
        chk({tag, "_pix_data"}, int'(pix_data),  0);
        chk({tag, "_cmd_strobe"}, int'(cmd_strobe), 0);
        chk({tag, "_cmd_code"}, int'(cmd_code),  0);
        check_flags(tag);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout at cyc %0d, required completion", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int cmds[10] = '{'h2A, 'h2B, 'h2C, 'h2C, 'h36, 'h10, 'h11, 'h28, 'h29, 'h3A};

        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("por");
        rst_n = 1'b1;
        repeat (SS + 2) @(negedge clk);

        // First pixels at default window origin.
        bus_write(0, 16'h002C);
        bus_write(1, 16'hF800);
        bus_write(1, 16'h07E0);

        // 2x2 window with wrap back to its origin.
        foreach (cmds[i]) ;
        bus_write(0, 16'h002A);
        bus_write(1, 16'h0000); bus_write(1, 16'h000A);
        bus_write(1, 16'h0000); bus_write(1, 16'h000B);
        bus_write(0, 16'h002B);
        bus_write(1, 16'h0000); bus_write(1, 16'h0005);
        bus_write(1, 16'h0000); bus_write(1, 16'h0006);
        bus_write(0, 16'h002C);
        for (int i = 0; i < 5; i++) bus_write(1, 16'(16'hA000 + i));

        // Interrupted CASET must leave the window intact.
        bus_write(0, 16'h002A);
        bus_write(1, 16'h0000); bus_write(1, 16'h0014);
        bus_write(0, 16'h0029);
        bus_write(0, 16'h002C);
        for (int i = 0; i < 3; i++) bus_write(1, 16'(16'hB000 + i));
        check_flags("dispon");

        // Flags and panel-reset pin.
        bus_write(0, 16'h0036); bus_write(1, 16'h00A0);
        check_flags("madctl");
        bus_write(0, 16'h0011);
        check_flags("slpout");
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (SS + 2) @(negedge clk);
        check_all_zero("pin_reset");

        // rst_n in the middle of a RAMWR stream.
        bus_write(0, 16'h0036); bus_write(1, 16'h00A5);
        bus_write(0, 16'h002C);
        for (int i = 0; i < 3; i++) bus_write(1, 16'(16'hC000 + i));
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("rst_mid");
        rst_n = 1'b1;
        repeat (SS + 2) @(negedge clk);
        bus_write(1, 16'h1234);

        // Full frame, then a fresh RAMWR restarts at the origin.
        bus_write(0, 16'h002C);
        @(negedge clk);
        n0 = pix_seen;
        for (int i = 0; i < W * H; i++) bus_write(1, 16'(i));
        @(negedge clk);
        chk("frame_count", pix_seen - n0, W * H);
        bus_write(0, 16'h002C);
        bus_write(1, 16'hFFFF);

        // Window straddling the visible edge: off-screen pixels suppressed.
        bus_write(0, 16'h002A);
        bus_write(1, 16'h0000); bus_write(1, 16'(W - 2));
        bus_write(1, 16'h0000); bus_write(1, 16'(W + 1));
        bus_write(0, 16'h002B);
        bus_write(1, 16'h0000); bus_write(1, 16'(H - 1));
        bus_write(1, 16'h0000); bus_write(1, 16'(H));
        bus_write(0, 16'h002C);
        for (int i = 0; i < 10; i++) bus_write(1, 16'(16'hD000 + i));

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rd_n = 1'($urandom);
            if ($urandom_range(0, 9) < 3) begin
                bus_write(0, 16'(cmds[$urandom_range(0, 9)]));
            end else if ($urandom_range(0, 3) == 0) begin
                bus_write(1, 16'($urandom));
            end else begin
                bus_write(1, 16'($urandom_range(0, W + 4)));
            end
        end
        rd_n = 1'b1;

        repeat (SS + 3) @(negedge clk);
        check_flags("final");
        chk("pix_queue_drained", pq.size(), 0);
        chk("cmd_queue_drained", cq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
